msrv32_machine_control: RTL and testbench

- Machine-mode trap sequencer that drives the strobes on the CSR file and selects the PC source.
- Detects exceptions, enabled pending interrupts, MRET and WFI from decoded flags, then runs the trap-entry and trap-return sequence.
- Sits between the decoder/interrupt inputs and the CSR file / PC mux. Generates set_cause, set_epc, i_or_e, cause, mie_clear, mie_set, instret_inc and misaligned_exception.

---
 rtl/msrv32_ctrl_pkg.sv | 39 +++
 rtl/msrv32_machine_control_if.sv | 53 +++++
 rtl/msrv32_trap_priority.sv | 68 ++++++
 rtl/msrv32_machine_control.sv | 129 ++++++++++++
 tb/tb_msrv32_machine_control.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/msrv32_ctrl_pkg.sv
// Shared encodings for the machine-mode trap sequencer: FSM states, PC source
// selects, trap cause codes and the decoded trap descriptor.
package msrv32_ctrl_pkg;

   localparam int unsigned CAUSE_W  = 4;
   localparam int unsigned PC_SRC_W = 2;

   typedef enum logic [2:0] {
      ST_RESET       = 3'd0,
      ST_OPERATING   = 3'd1,
      ST_WAIT_IRQ    = 3'd2,
      ST_TRAP_TAKEN  = 3'd3,
      ST_TRAP_RETURN = 3'd4
   } ctrl_state_e;

   localparam logic [PC_SRC_W-1:0] PC_SRC_BOOT = 2'b00;
   localparam logic [PC_SRC_W-1:0] PC_SRC_EPC  = 2'b01;
   localparam logic [PC_SRC_W-1:0] PC_SRC_TRAP = 2'b10;
   localparam logic [PC_SRC_W-1:0] PC_SRC_NEXT = 2'b11;

   localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_INSTR = 4'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
   localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT       = 4'd3;
   localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
   localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_STORE = 4'd6;
   localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M          = 4'd11;

   localparam logic [CAUSE_W-1:0] CAUSE_IRQ_SOFTWARE = 4'd3;
   localparam logic [CAUSE_W-1:0] CAUSE_IRQ_TIMER    = 4'd7;
   localparam logic [CAUSE_W-1:0] CAUSE_IRQ_EXTERNAL = 4'd11;

   // Winning trap after priority resolution.
   typedef struct packed {
      logic               i_or_e;
      logic [CAUSE_W-1:0] cause;
      logic               misaligned;
   } trap_info_t;

endpackage

// File: rtl/msrv32_machine_control_if.sv
// Decoder/interrupt flags into the trap sequencer and CSR/PC strobes out of it.
interface msrv32_machine_control_if;
   import msrv32_ctrl_pkg::*;

   logic                stall_in;
   logic                illegal_instr_in;
   logic                misaligned_instr_in;
   logic                misaligned_load_in;
   logic                misaligned_store_in;
   logic                ecall_in;
   logic                ebreak_in;
   logic                mret_in;
   logic                wfi_in;
   logic                mie_in;
   logic                meie_in;
   logic                mtie_in;
   logic                msie_in;
   logic                meip_in;
   logic                mtip_in;
   logic                msip_in;

   logic                i_or_e_out;
   logic [CAUSE_W-1:0]  cause_out;
   logic                set_cause_out;
   logic                set_epc_out;
   logic                mie_clear_out;
   logic                mie_set_out;
   logic                instret_inc_out;
   logic                misaligned_exception_out;
   logic [PC_SRC_W-1:0] pc_src_out;
   logic                flush_out;

   // Pipeline / CSR side that supplies the flags.
   modport master (
      output stall_in, illegal_instr_in, misaligned_instr_in, misaligned_load_in,
             misaligned_store_in, ecall_in, ebreak_in, mret_in, wfi_in,
             mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
      input  i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out,
             mie_set_out, instret_inc_out, misaligned_exception_out,
             pc_src_out, flush_out
   );

   // Trap sequencer side.
   modport slave (
      input  stall_in, illegal_instr_in, misaligned_instr_in, misaligned_load_in,
             misaligned_store_in, ecall_in, ebreak_in, mret_in, wfi_in,
             mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
      output i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out,
             mie_set_out, instret_inc_out, misaligned_exception_out,
             pc_src_out, flush_out
   );

endinterface

// File: rtl/msrv32_trap_priority.sv
// Combinational trap detection and priority resolution: exceptions first, then
// external > software > timer interrupts.
module msrv32_trap_priority
   import msrv32_ctrl_pkg::*;
(
   input  logic       illegal_instr,
   input  logic       misaligned_instr,
   input  logic       misaligned_load,
   input  logic       misaligned_store,
   input  logic       ecall,
   input  logic       ebreak,
   input  logic       mie,
   input  logic       meie,
   input  logic       mtie,
   input  logic       msie,
   input  logic       meip,
   input  logic       mtip,
   input  logic       msip,
   output logic       exc,
   output logic       irq_pend,
   output logic       irq_wake,
   output trap_info_t info
);

   logic ext_irq;
   logic sw_irq;
   logic tmr_irq;

   assign ext_irq  = meie & meip;
   assign sw_irq   = msie & msip;
   assign tmr_irq  = mtie & mtip;
   // WFI wakes on any enabled pending source even with global MIE off.
   assign irq_wake = ext_irq | sw_irq | tmr_irq;
   assign irq_pend = mie & irq_wake;
   assign exc      = misaligned_instr | illegal_instr | ebreak |
                     misaligned_load | misaligned_store | ecall;

   // Pick the highest-priority trap and its cause code.
   always_comb begin
      info = '0;
      if (misaligned_instr) begin
         info.cause      = CAUSE_MISALIGNED_INSTR;
         info.misaligned = 1'b1;
      end else if (illegal_instr) begin
         info.cause      = CAUSE_ILLEGAL_INSTR;
      end else if (ebreak) begin
         info.cause      = CAUSE_BREAKPOINT;
      end else if (misaligned_load) begin
         info.cause      = CAUSE_MISALIGNED_LOAD;
         info.misaligned = 1'b1;
      end else if (misaligned_store) begin
         info.cause      = CAUSE_MISALIGNED_STORE;
         info.misaligned = 1'b1;
      end else if (ecall) begin
         info.cause      = CAUSE_ECALL_M;
      end else if (ext_irq) begin
         info.i_or_e     = 1'b1;
         info.cause      = CAUSE_IRQ_EXTERNAL;
      end else if (sw_irq) begin
         info.i_or_e     = 1'b1;
         info.cause      = CAUSE_IRQ_SOFTWARE;
      end else if (tmr_irq) begin
         info.i_or_e     = 1'b1;
         info.cause      = CAUSE_IRQ_TIMER;
      end
   end

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap sequencer: trap entry/return FSM driving CSR strobes and
// the PC source select.
module msrv32_machine_control
   import msrv32_ctrl_pkg::*;
(
   input logic                     clk_in,
   input logic                     rst_in,
   msrv32_machine_control_if.slave bus
);

   ctrl_state_e         state;
   ctrl_state_e         next_state;
   logic                exc;
   logic                irq_pend;
   logic                irq_wake;
   trap_info_t          info;

   logic                set_cause;
   logic                set_epc;
   logic                mie_clear;
   logic                mie_set;
   logic                i_or_e;
   logic [CAUSE_W-1:0]  cause;
   logic                misaligned;
   logic                instret_inc;
   logic [PC_SRC_W-1:0] pc_src;
   logic                flush;

   msrv32_trap_priority u_trap_priority (
      .illegal_instr    (bus.illegal_instr_in),
      .misaligned_instr (bus.misaligned_instr_in),
      .misaligned_load  (bus.misaligned_load_in),
      .misaligned_store (bus.misaligned_store_in),
      .ecall            (bus.ecall_in),
      .ebreak           (bus.ebreak_in),
      .mie              (bus.mie_in),
      .meie             (bus.meie_in),
      .mtie             (bus.mtie_in),
      .msie             (bus.msie_in),
      .meip             (bus.meip_in),
      .mtip             (bus.mtip_in),
      .msip             (bus.msip_in),
      .exc              (exc),
      .irq_pend         (irq_pend),
      .irq_wake         (irq_wake),
      .info             (info)
   );

   // State register with synchronous active-low reset.
   always_ff @(posedge clk_in) begin
      if (!rst_in) state <= ST_RESET;
      else         state <= next_state;
   end

   // Next-state and strobe decode.
   always_comb begin
      next_state  = state;
      set_cause   = 1'b0;
      set_epc     = 1'b0;
      mie_clear   = 1'b0;
      mie_set     = 1'b0;
      i_or_e      = 1'b0;
      cause       = '0;
      misaligned  = 1'b0;
      instret_inc = 1'b0;
      pc_src      = PC_SRC_BOOT;
      flush       = 1'b0;
      unique case (state)
         ST_RESET: begin
            flush      = 1'b1;
            next_state = ST_OPERATING;
         end
         ST_OPERATING: begin
            pc_src = PC_SRC_NEXT;
            if (!bus.stall_in) begin
               if (exc || irq_pend) begin
                  set_cause  = 1'b1;
                  set_epc    = 1'b1;
                  mie_clear  = 1'b1;
                  i_or_e     = info.i_or_e;
                  cause      = info.cause;
                  misaligned = info.misaligned;
                  next_state = ST_TRAP_TAKEN;
               end else if (bus.mret_in) begin
                  next_state = ST_TRAP_RETURN;
               end else if (bus.wfi_in) begin
                  instret_inc = 1'b1;
                  next_state  = ST_WAIT_IRQ;
               end else begin
                  instret_inc = 1'b1;
               end
            end
         end
         ST_WAIT_IRQ: begin
            pc_src = PC_SRC_NEXT;
            flush  = 1'b1;
            if (irq_wake) next_state = ST_OPERATING;
         end
         ST_TRAP_TAKEN: begin
            pc_src     = PC_SRC_TRAP;
            flush      = 1'b1;
            next_state = ST_OPERATING;
         end
         ST_TRAP_RETURN: begin
            pc_src      = PC_SRC_EPC;
            mie_set     = 1'b1;
            flush       = 1'b1;
            instret_inc = 1'b1;
            next_state  = ST_OPERATING;
         end
         default: begin
            flush      = 1'b1;
            next_state = ST_RESET;
         end
      endcase
   end

   assign bus.set_cause_out            = set_cause;
   assign bus.set_epc_out              = set_epc;
   assign bus.mie_clear_out            = mie_clear;
   assign bus.mie_set_out              = mie_set;
   assign bus.i_or_e_out               = i_or_e;
   assign bus.cause_out                = cause;
   assign bus.misaligned_exception_out = misaligned;
   assign bus.instret_inc_out          = instret_inc;
   assign bus.pc_src_out               = pc_src;
   assign bus.flush_out                = flush;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed bench for the machine-mode trap sequencer: a vector table for
// single-instruction decisions plus hand sequences for reset, WFI and stall.
module tb_msrv32_machine_control;
   import msrv32_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   msrv32_machine_control_if bus ();

   msrv32_machine_control dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .bus    (bus)
   );

   localparam logic [15:0] B_STALL = 16'h0001;
   localparam logic [15:0] B_ILL   = 16'h0002;
   localparam logic [15:0] B_MINS  = 16'h0004;
   localparam logic [15:0] B_MLD   = 16'h0008;
   localparam logic [15:0] B_MST   = 16'h0010;
   localparam logic [15:0] B_ECALL = 16'h0020;
   localparam logic [15:0] B_EBRK  = 16'h0040;
   localparam logic [15:0] B_MRET  = 16'h0080;
   localparam logic [15:0] B_WFI   = 16'h0100;
   localparam logic [15:0] B_MIE   = 16'h0200;
   localparam logic [15:0] B_MEIE  = 16'h0400;
   localparam logic [15:0] B_MTIE  = 16'h0800;
   localparam logic [15:0] B_MSIE  = 16'h1000;
   localparam logic [15:0] B_MEIP  = 16'h2000;
   localparam logic [15:0] B_MTIP  = 16'h4000;
   localparam logic [15:0] B_MSIP  = 16'h8000;
   localparam logic [15:0] B_ALLIRQ = B_MIE | B_MEIE | B_MTIE | B_MSIE |
                                      B_MEIP | B_MTIP | B_MSIP;

   typedef struct packed {
      logic       set_cause;
      logic       set_epc;
      logic       mie_clear;
      logic       mie_set;
      logic       i_or_e;
      logic [3:0] cause;
      logic       misaligned;
      logic       instret;
      logic [1:0] pc_src;
      logic       flush;
   } out_t;

   typedef struct {
      string       name;
      logic [15:0] in;
      out_t        now;
      out_t        nxt;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (sc,epc,clr,set,ie,cause,mis,ret,pc,fl)",
                  name, act, exp);
      end
   endtask

   task automatic apply(input logic [15:0] m);
      bus.stall_in            = m[0];
      bus.illegal_instr_in    = m[1];
      bus.misaligned_instr_in = m[2];
      bus.misaligned_load_in  = m[3];
      bus.misaligned_store_in = m[4];
      bus.ecall_in            = m[5];
      bus.ebreak_in           = m[6];
      bus.mret_in             = m[7];
      bus.wfi_in              = m[8];
      bus.mie_in              = m[9];
      bus.meie_in             = m[10];
      bus.mtie_in             = m[11];
      bus.msie_in             = m[12];
      bus.meip_in             = m[13];
      bus.mtip_in             = m[14];
      bus.msip_in             = m[15];
   endtask

   function automatic out_t sample();
      out_t o;
      o.set_cause  = bus.set_cause_out;
      o.set_epc    = bus.set_epc_out;
      o.mie_clear  = bus.mie_clear_out;
      o.mie_set    = bus.mie_set_out;
      o.i_or_e     = bus.i_or_e_out;
      o.cause      = bus.cause_out;
      o.misaligned = bus.misaligned_exception_out;
      o.instret    = bus.instret_inc_out;
      o.pc_src     = bus.pc_src_out;
      o.flush      = bus.flush_out;
      return o;
   endfunction

   function automatic out_t o_trap(input logic ie, input logic [3:0] c, input logic mis);
      out_t o = '0;
      o.set_cause  = 1'b1;
      o.set_epc    = 1'b1;
      o.mie_clear  = 1'b1;
      o.i_or_e     = ie;
      o.cause      = c;
      o.misaligned = mis;
      o.pc_src     = 2'b11;
      return o;
   endfunction

   function automatic out_t o_run(input logic ret);
      out_t o = '0;
      o.instret = ret;
      o.pc_src  = 2'b11;
      return o;
   endfunction

   function automatic out_t o_pc(input logic [1:0] pc, input logic fl, input logic mset,
                                 input logic ret);
      out_t o = '0;
      o.pc_src  = pc;
      o.flush   = fl;
      o.mie_set = mset;
      o.instret = ret;
      return o;
   endfunction

   task automatic add(input string n, input logic [15:0] in, input out_t now, input out_t nxt);
      vec_t v;
      v.name = n;
      v.in   = in;
      v.now  = now;
      v.nxt  = nxt;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      out_t o_reset, o_taken, o_ret, o_wait, o_op;
      o_reset = o_pc(2'b00, 1'b1, 1'b0, 1'b0);
      o_taken = o_pc(2'b10, 1'b1, 1'b0, 1'b0);
      o_ret   = o_pc(2'b01, 1'b1, 1'b1, 1'b1);
      o_wait  = o_pc(2'b11, 1'b1, 1'b0, 1'b0);
      o_op    = o_run(1'b1);

      add("idle",            16'h0000,                      o_run(1'b1),             o_op);
      add("ill_ecall",       B_ILL | B_ECALL,               o_trap(1'b0, 4'd2, 1'b0),  o_taken);
      add("mis_load",        B_MLD,                         o_trap(1'b0, 4'd4, 1'b1),  o_taken);
      add("mins_ill_mst",    B_MINS | B_ILL | B_MST,        o_trap(1'b0, 4'd0, 1'b1),  o_taken);
      add("mis_store",       B_MST,                         o_trap(1'b0, 4'd6, 1'b1),  o_taken);
      add("ebreak_ecall",    B_EBRK | B_ECALL,              o_trap(1'b0, 4'd3, 1'b0),  o_taken);
      add("ecall",           B_ECALL,                       o_trap(1'b0, 4'd11, 1'b0), o_taken);
      add("irq_all",         B_ALLIRQ,                      o_trap(1'b1, 4'd11, 1'b0), o_taken);
      add("irq_sw_tmr",      B_ALLIRQ & ~B_MEIP,            o_trap(1'b1, 4'd3, 1'b0),  o_taken);
      add("irq_tmr",         B_MIE | B_MTIE | B_MTIP,       o_trap(1'b1, 4'd7, 1'b0),  o_taken);
      add("irq_mie_off",     B_ALLIRQ & ~B_MIE,             o_run(1'b1),             o_op);
      add("irq_not_enabled", B_MIE | B_MEIP | B_MTIE,       o_run(1'b1),             o_op);
      add("mret",            B_MRET,                        o_run(1'b0),             o_ret);
      add("mret_vs_tmr",     B_MRET | B_MIE | B_MTIE | B_MTIP, o_trap(1'b1, 4'd7, 1'b0), o_taken);
      add("ecall_vs_irq",    B_ECALL | B_ALLIRQ,            o_trap(1'b0, 4'd11, 1'b0), o_taken);
      add("stall_ecall",     B_STALL | B_ECALL,             o_run(1'b0),             o_op);
      add("mld_vs_irq",      B_MLD | B_ALLIRQ,              o_trap(1'b0, 4'd4, 1'b1),  o_taken);
      add("stall_mret",      B_STALL | B_MRET,              o_run(1'b0),             o_op);

      // Reset held for three edges, then released.
      rst_n = 1'b0;
      apply(16'h0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_hold", sample(), o_reset);
      end
      rst_n = 1'b1;
      #1 check("reset_exit", sample(), o_reset);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("operating_retire", sample(), o_op);
      end

      // Table: decision in OPERATING, then the state reached one edge later.
      foreach (vecs[i]) begin
         apply(vecs[i].in);
         #1 check({vecs[i].name, "_now"}, sample(), vecs[i].now);
         tick();
         apply(16'h0000);
         #1 check({vecs[i].name, "_next"}, sample(), vecs[i].nxt);
         if (vecs[i].nxt.pc_src != 2'b11) tick();
      end

      // WFI with MIE off: wake on meie+meip without taking a trap.
      apply(B_WFI);
      #1 check("wfi_issue", sample(), o_op);
      tick();
      apply(16'h0000);
      #1 check("wfi_wait", sample(), o_wait);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("wfi_hold", sample(), o_wait);
      end
      apply(B_MEIE | B_MEIP);
      #1 check("wfi_wake_cycle", sample(), o_wait);
      tick();
      check("wfi_wake_no_trap", sample(), o_op);
      apply(16'h0000);

      // WFI with MIE on: wake, then trap on the following cycle.
      apply(B_WFI);
      tick();
      apply(16'h0000);
      #1 check("wfi2_wait", sample(), o_wait);
      apply(B_MIE | B_MTIE | B_MTIP);
      #1 check("wfi2_wake_cycle", sample(), o_wait);
      tick();
      check("wfi2_trap", sample(), o_trap(1'b1, 4'd7, 1'b0));
      tick();
      apply(16'h0000);
      #1 check("wfi2_taken", sample(), o_taken);
      tick();
      check("wfi2_back", sample(), o_op);

      // Stalled ECALL holds off, then traps; reset lands mid-trap.
      apply(B_STALL | B_ECALL);
      for (int i = 0; i < 3; i++) begin
         #1 check("stall_hold", sample(), o_run(1'b0));
         tick();
      end
      apply(B_ECALL);
      #1 check("stall_release", sample(), o_trap(1'b0, 4'd11, 1'b0));
      tick();
      apply(16'h0000);
      #1 check("stall_taken", sample(), o_taken);
      rst_n = 1'b0;
      #1 check("taken_before_reset_edge", sample(), o_taken);
      tick();
      check("reset_mid_trap", sample(), o_reset);
      rst_n = 1'b1;
      tick();
      check("reset_recover", sample(), o_op);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
